cdb_arbiter: RTL and testbench

- Shares the two-lane common data bus (CDB) among `NUM_REQ` result producers (ALU, load/store buffer, branch unit, ...).
- Each producer hands over one (tag, data) result through a valid/ready handshake into a per-requester holding register.
- A round-robin arbiter grants up to two held results per cycle and drives them onto the registered 74-bit CDB consumed by the reservation station and reorder buffer.
- Flush discards every pending result.

---
 rtl/cdb_pkg.sv | 34 +++
 rtl/cdb_arbiter_rr_pick2.sv | 49 ++++
 rtl/cdb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the common data bus (CDB).
// Holds the default tag/data widths, the lane layout used by the arbiter,
// reservation station and reorder buffer, a lane-pack helper and the
// requester index assignments.
package cdb_pkg;

  localparam int TAG_W      = 4;
  localparam int DATA_W     = 32;
  localparam int CDB_LANE_W = 1 + TAG_W + DATA_W;
  localparam int CDB_W      = 2 * CDB_LANE_W;

  // Field offsets within one lane; lane1 sits CDB_LANE_W bits above lane0.
  localparam int LANE_DATA_LSB = 0;
  localparam int LANE_DATA_MSB = DATA_W - 1;
  localparam int LANE_TAG_LSB  = DATA_W;
  localparam int LANE_TAG_MSB  = DATA_W + TAG_W - 1;
  localparam int LANE_VALID    = DATA_W + TAG_W;

  // Requester slots on the arbiter.
  localparam int REQ_ALU = 0;
  localparam int REQ_LSB = 1;
  localparam int REQ_BRU = 2;
  localparam int REQ_MUL = 3;

  typedef logic [CDB_LANE_W-1:0] cdb_lane_t;

  // Build one lane as {valid, tag, data}.
  function automatic cdb_lane_t lane_pack(input logic valid,
                                          input logic [TAG_W-1:0] tag,
                                          input logic [DATA_W-1:0] data);
    return {valid, tag, data};
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: combinational circular two-winner picker.
// Scans `held` circularly starting at `ptr`; the first set index becomes
// lane0, the next set index after it (circularly) becomes lane1.
// Ports:
//   held        in  NUM_REQ  pending-entry mask
//   ptr         in  PTR_W    scan start index
//   lane0_idx   out PTR_W    first winner index
//   lane0_valid out 1        a first winner exists
//   lane1_idx   out PTR_W    second winner index
//   lane1_valid out 1        a second winner exists
module rr_pick2
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] held,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   lane0_idx,
  output logic               lane0_valid,
  output logic [PTR_W-1:0]   lane1_idx,
  output logic               lane1_valid
);

  // Circular scan from ptr; taking the second hit of this scan equals a
  // scan from lane0+1 because nothing between ptr and lane0 is held.
  always_comb begin
    lane0_idx   = '0;
    lane0_valid = 1'b0;
    lane1_idx   = '0;
    lane1_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (held[(int'(ptr) + k) % NUM_REQ]) begin
        if (!lane0_valid) begin
          lane0_valid = 1'b1;
          lane0_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
        end else if (!lane1_valid) begin
          lane1_valid = 1'b1;
          lane1_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
        end else begin
          lane1_valid = lane1_valid;
        end
      end else begin
        lane0_valid = lane0_valid;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two-lane common data bus among NUM_REQ producers.
// Each producer hands one (tag, data) result into a holding register via a
// valid/ready handshake; a round-robin picker grants up to two held results
// per cycle onto the registered CDB. Flush discards all pending results.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         discard pending and in-flight results
//   req_valid     per-producer offer
//   req_tag       per-producer tag, slice [i*TAG_W +: TAG_W]
//   req_data      per-producer data, slice [i*DATA_W +: DATA_W]
//   req_ready     per-producer accept (combinational from state and grant)
//   cdb           registered bus, lane1 above lane0, each {valid, tag, data}
//   cdb_conflict  registered: more than two entries were held last cycle
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = cdb_pkg::TAG_W,
  parameter int DATA_W  = cdb_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [2*(1+TAG_W+DATA_W)-1:0] cdb,
  output logic                        cdb_conflict
);
  import cdb_pkg::*;

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int LANE_W = 1 + TAG_W + DATA_W;

  logic [NUM_REQ-1:0] held_r;
  logic [TAG_W-1:0]   tag_r  [NUM_REQ];
  logic [DATA_W-1:0]  data_r [NUM_REQ];
  logic [PTR_W-1:0]   ptr_r;
  logic [2*LANE_W-1:0] cdb_r;
  logic               conflict_r;

  logic [PTR_W-1:0]   lane0_idx_s;
  logic               lane0_valid_s;
  logic [PTR_W-1:0]   lane1_idx_s;
  logic               lane1_valid_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] load_s;
  logic [PTR_W-1:0]   ptr_next_s;
  logic [LANE_W-1:0]  lane0_s;
  logic [LANE_W-1:0]  lane1_s;
  logic               conflict_s;

  // Advance an index by one with wrap at NUM_REQ-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return idx + PTR_W'(1);
    end
  endfunction

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .held        (held_r),
    .ptr         (ptr_r),
    .lane0_idx   (lane0_idx_s),
    .lane0_valid (lane0_valid_s),
    .lane1_idx   (lane1_idx_s),
    .lane1_valid (lane1_valid_s)
  );

  // One-hot grant mask from the two picked lanes.
  always_comb begin
    grant_s = '0;
    if (lane0_valid_s) begin
      grant_s[lane0_idx_s] = 1'b1;
    end else begin
      grant_s = grant_s;
    end
    if (lane1_valid_s) begin
      grant_s[lane1_idx_s] = 1'b1;
    end else begin
      grant_s = grant_s;
    end
  end

  // Ready: a slot frees up when empty or being granted this cycle, so a
  // producer can stream one result per cycle; flush blocks all capture.
  always_comb begin
    ready_s = '0;
    if (flush) begin
      ready_s = '0;
    end else begin
      ready_s = ~held_r | grant_s;
    end
    load_s = req_valid & ready_s;
  end

  // Conflict flag: more than two results waiting.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + int'(held_r[i]);
    end
    conflict_s = (cnt > 2);
  end

  // Pointer moves past the last granted index; unchanged without a grant.
  always_comb begin
    ptr_next_s = ptr_r;
    if (lane1_valid_s) begin
      ptr_next_s = ptr_inc(lane1_idx_s);
    end else if (lane0_valid_s) begin
      ptr_next_s = ptr_inc(lane0_idx_s);
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Lane payloads; an unused lane is driven all-zero.
  always_comb begin
    lane0_s = '0;
    lane1_s = '0;
    if (lane0_valid_s) begin
      lane0_s = {1'b1, tag_r[lane0_idx_s], data_r[lane0_idx_s]};
    end else begin
      lane0_s = '0;
    end
    if (lane1_valid_s) begin
      lane1_s = {1'b1, tag_r[lane1_idx_s], data_r[lane1_idx_s]};
    end else begin
      lane1_s = '0;
    end
  end

  // Holding registers: grant clears, a same-cycle handshake reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
      end
    end else if (flush) begin
      held_r <= '0;
    end else begin
      held_r <= (held_r & ~grant_s) | load_s;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load_s[i]) begin
          tag_r[i]  <= req_tag[i*TAG_W +: TAG_W];
          data_r[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // CDB and conflict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_r      <= '0;
      conflict_r <= 1'b0;
    end else if (flush) begin
      cdb_r      <= '0;
      conflict_r <= 1'b0;
    end else begin
      cdb_r      <= {lane1_s, lane0_s};
      conflict_r <= conflict_s;
    end
  end

  // Round-robin pointer; flush leaves it where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (flush) begin
      ptr_r <= ptr_r;
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  assign req_ready    = ready_s;
  assign cdb          = cdb_r;
  assign cdb_conflict = conflict_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed, table-driven bench for cdb_arbiter at defaults
// (NUM_REQ=4, TAG_W=4, DATA_W=32), plus hand-written sequences for the
// asynchronous reset and the single DEADBEEF result.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic [73:0] cdb;
  logic        cdb_conflict;

  int compared   = 0;
  int mismatched = 0;

  cdb_arbiter #(
    .NUM_REQ (4),
    .TAG_W   (4),
    .DATA_W  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cdb          (cdb),
    .cdb_conflict (cdb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] tags;
    logic        flush;
    logic [3:0]  ready;   // expected req_ready before the edge
    logic        l0v;     // expected after the edge
    logic [3:0]  l0t;
    logic        l1v;
    logic [3:0]  l1t;
    logic        conf;
    logic [1:0]  ptr;
  } vec_t;

  vec_t vec [21];

  function automatic vec_t mk(input logic [3:0] valid, input logic [15:0] tags,
                              input logic fl, input logic [3:0] rdy,
                              input logic l0v, input logic [3:0] l0t,
                              input logic l1v, input logic [3:0] l1t,
                              input logic conf, input logic [1:0] ptr);
    vec_t v;
    v.valid = valid; v.tags = tags; v.flush = fl; v.ready = rdy;
    v.l0v = l0v; v.l0t = l0t; v.l1v = l1v; v.l1t = l1t;
    v.conf = conf; v.ptr = ptr;
    return v;
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] tag);
    return {16'hC0DE, 12'h000, tag};
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [15:0] tags);
    req_valid = valid;
    req_tag   = tags;
    for (int i = 0; i < 4; i++) begin
      req_data[i*32 +: 32] = data_of(tags[i*4 +: 4]);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 4'b0000;
    req_tag = 16'h0000; req_data = 128'h0;

    // Single result (tag 3), idle, two simultaneous, load idx1 to steer ptr
    vec[0]  = mk(4'b0001, 16'h0003, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
    vec[1]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 2'd1);
    vec[2]  = mk(4'b0110, 16'h0650, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1);
    vec[3]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 2'd3);
    vec[4]  = mk(4'b0010, 16'h0070, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd3);
    vec[5]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 2'd2);
    // Four-way contention from ptr=2: {2,3} then {0,1}
    vec[6]  = mk(4'b1111, 16'hBA98, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2);
    vec[7]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1100, 1'b1, 4'hA, 1'b1, 4'hB, 1'b1, 2'd0);
    vec[8]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'h8, 1'b1, 4'h9, 1'b0, 2'd2);
    // Streaming tags 0..7 on producer 0
    vec[9]  = mk(4'b0001, 16'h0000, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2);
    for (int k = 1; k < 8; k++) begin
      vec[9+k] = mk(4'b0001, 16'(k), 1'b0, 4'b1111, 1'b1, 4'(k-1), 1'b0, 4'h0, 1'b0, 2'd1);
    end
    vec[17] = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 2'd1);
    // Flush with three held and a request on producer 2
    vec[18] = mk(4'b1011, 16'hE0DC, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1);
    vec[19] = mk(4'b0100, 16'h0F00, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1);
    vec[20] = mk(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdb", 74'(cdb), 74'h0);
    chk("rst_conflict", 74'(cdb_conflict), 74'h0);
    chk("rst_held", 74'(dut.held_r), 74'h0);
    chk("rst_ptr", 74'(dut.ptr_r), 74'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 74'(req_ready), 74'hF);

    // Table
    for (int n = 0; n < 21; n++) begin
      drive(vec[n].valid, vec[n].tags);
      flush = vec[n].flush;
      #1;
      chk($sformatf("v%0d_ready", n), 74'(req_ready), 74'(vec[n].ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_l0v", n), 74'(cdb[36]), 74'(vec[n].l0v));
      if (vec[n].l0v) begin
        chk($sformatf("v%0d_l0tag", n), 74'(cdb[35:32]), 74'(vec[n].l0t));
        chk($sformatf("v%0d_l0data", n), 74'(cdb[31:0]), 74'(data_of(vec[n].l0t)));
      end
      chk($sformatf("v%0d_l1v", n), 74'(cdb[73]), 74'(vec[n].l1v));
      if (vec[n].l1v) begin
        chk($sformatf("v%0d_l1tag", n), 74'(cdb[72:69]), 74'(vec[n].l1t));
        chk($sformatf("v%0d_l1data", n), 74'(cdb[68:37]), 74'(data_of(vec[n].l1t)));
      end
      chk($sformatf("v%0d_conflict", n), 74'(cdb_conflict), 74'(vec[n].conf));
      chk($sformatf("v%0d_ptr", n), 74'(dut.ptr_r), 74'(vec[n].ptr));
    end
    flush = 1'b0;

    // Async reset mid-stream: tag 9 on the bus, three entries held
    drive(4'b0001, 16'h0009);
    @(posedge clk);
    #1;
    drive(4'b0111, 16'h0421);
    @(posedge clk);
    #1;
    chk("ar_pre_l0", 74'(cdb[36:32]), 74'h19);
    chk("ar_pre_held", 74'(dut.held_r), 74'h7);
    drive(4'b0000, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cdb", 74'(cdb), 74'h0);
    chk("ar_held", 74'(dut.held_r), 74'h0);
    chk("ar_ptr", 74'(dut.ptr_r), 74'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("ar_ready", 74'(req_ready), 74'hF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ar_post%0d_valids", k), 74'({cdb[73], cdb[36]}), 74'h0);
    end

    // Single ALU result 0xDEADBEEF, tag 3, from a fresh pointer
    req_valid = 4'b0001;
    req_tag   = 16'h0003;
    req_data  = 128'h0;
    req_data[31:0] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    chk("alu_lane0", 74'(cdb[36:0]), 74'(lane_pack(1'b1, 4'h3, 32'hDEADBEEF)));
    chk("alu_l1v", 74'(cdb[73]), 74'h0);
    chk("alu_ptr", 74'(dut.ptr_r), 74'h1);
    @(posedge clk);
    #1;
    chk("alu_once", 74'(cdb[36]), 74'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
